// File: rtl/wb_master.sv
// wb_master: pipelined Wishbone B4 initiator splitting one wide core request into BEATS bus beats.
// Optional watchdog abort is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_master #(
  parameter int OPTN_WB_DATA_WIDTH = 16,
  parameter int OPTN_WB_ADDR_WIDTH = 32,
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_TIMEOUT       = 16
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            i_biu_en,
  input  logic                            i_biu_we,
  input  logic [OPTN_WB_ADDR_WIDTH-1:0]   i_biu_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]      i_biu_data,
  output logic [OPTN_DATA_WIDTH-1:0]      o_biu_data,
  output logic                            o_biu_busy,
  output logic                            o_biu_done,
  output logic                            o_biu_err,
  output logic                            o_wb_cyc,
  output logic                            o_wb_stb,
  output logic                            o_wb_we,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]   o_wb_data,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb_data,
  input  logic                            i_wb_ack,
  input  logic                            i_wb_stall
);

  localparam int WW    = OPTN_WB_DATA_WIDTH;
  localparam int AW    = OPTN_WB_ADDR_WIDTH;
  localparam int DW    = OPTN_DATA_WIDTH;
  localparam int WB_WORD_SIZE = WW / 8;
  localparam int BEATS = DW / WW;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int LINE_BYTES = DW / 8;

  localparam logic [AW-1:0] ADDR_MASK = ~AW'(LINE_BYTES - 1);
  localparam logic [AW-1:0] ADDR_STEP = AW'(WB_WORD_SIZE);
  localparam logic [CW-1:0] LAST     = CW'(BEATS - 1);
  localparam logic [CW-1:0] ALL      = CW'(BEATS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic          we_q;
  logic [DW-1:0] wr_buf;
  logic [CW-1:0] iss_cnt;
  logic [CW-1:0] ack_cnt;

  logic active;
  logic beat_acc;
  logic ack_ok;
  logic issue_last;
  logic acks_done;
  logic finish;
  logic wd_hit;

  assign active     = (state == REQ) || (state == WAIT);
  assign beat_acc   = (state == REQ) && o_wb_stb && !i_wb_stall;
  assign ack_ok     = active && i_wb_ack && (ack_cnt != ALL);
  assign issue_last = beat_acc && (iss_cnt == LAST);
  assign acks_done  = (ack_cnt == ALL) ||
                      (ack_ok && (ack_cnt == LAST));

  // The last ack may land on the same edge as the last issue,
  // so REQ can finish directly without visiting WAIT.
  assign finish = wd_hit ||
                  ((state == REQ) && issue_last && acks_done) ||
                  ((state == WAIT) && acks_done);

  // Bus FSM, beat/ack counters and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      wr_buf     <= '0;
      iss_cnt    <= '0;
      ack_cnt    <= '0;
      o_biu_data <= '0;
      o_biu_busy <= 1'b0;
      o_biu_done <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_sel   <= '0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
    end else begin
      o_biu_done <= 1'b0;

      if (beat_acc)
        iss_cnt <= iss_cnt + CNT_ONE;

      if (ack_ok) begin
        ack_cnt <= ack_cnt + CNT_ONE;
        if (!we_q) begin
          for (int k = 0; k < BEATS; k++) begin
            if (ack_cnt == CW'(k))
              o_biu_data[k*WW +: WW] <= i_wb_data;
          end
        end
      end

      if (finish) begin
        state      <= DONE;
        o_biu_done <= 1'b1;
        o_wb_cyc   <= 1'b0;
        o_wb_stb   <= 1'b0;
        o_wb_we    <= 1'b0;
        o_wb_sel   <= '0;
        o_wb_addr  <= '0;
        o_wb_data  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_biu_en) begin
              state      <= REQ;
              we_q       <= i_biu_we;
              iss_cnt    <= '0;
              ack_cnt    <= '0;
              o_biu_data <= '0;
              o_biu_busy <= 1'b1;
              o_wb_cyc   <= 1'b1;
              o_wb_stb   <= 1'b1;
              o_wb_we    <= i_biu_we;
              o_wb_sel   <= '1;
              o_wb_addr  <= i_biu_addr & ADDR_MASK;
              o_wb_data  <= i_biu_we ?
                            i_biu_data[WW-1:0] : '0;
              wr_buf     <= i_biu_we ?
                            (i_biu_data >> WW) : '0;
            end
          end
          REQ: begin
            if (issue_last) begin
              state     <= WAIT;
              o_wb_stb  <= 1'b0;
              o_wb_sel  <= '0;
              o_wb_addr <= '0;
              o_wb_data <= '0;
            end else if (beat_acc) begin
              o_wb_addr <= o_wb_addr + ADDR_STEP;
              o_wb_data <= wr_buf[WW-1:0];
              wr_buf    <= wr_buf >> WW;
            end
          end
          WAIT: begin
            state <= WAIT;
          end
          DONE: begin
            state      <= IDLE;
            o_biu_busy <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(OPTN_TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(OPTN_TIMEOUT - 1);
  localparam logic [TW-1:0] WD_ONE  = TW'(1);

  logic [TW-1:0] wd_cnt;

  assign wd_hit = active && !beat_acc && !ack_ok &&
                  (wd_cnt == WD_LAST);

  // Watchdog: restarts on any bus progress, counts stalled owned cycles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      wd_cnt <= '0;
    else if (!active || beat_acc || ack_ok)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_ONE;
  end

  // Error flag pulses together with done on a watchdog abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      o_biu_err <= 1'b0;
    else
      o_biu_err <= wd_hit;
  end
`else
  logic unused_timeout;

  assign wd_hit         = 1'b0;
  assign o_biu_err      = 1'b0;
  // Timeout depth only matters when the watchdog is built in.
  assign unused_timeout = ^OPTN_TIMEOUT;
`endif

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed vectors plus corner sequences for wb_master.
// A small slave model supplies stall, delayed acks and read data.
module tb_wb_master;

  logic        clk;
  logic        n_rst;
  logic        biu_en;
  logic        biu_we;
  logic [31:0] biu_addr;
  logic [31:0] biu_wdata;
  logic [31:0] biu_rdata;
  logic        biu_busy;
  logic        biu_done;
  logic        biu_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [31:0] wb_addr;
  logic [15:0] wb_wdata;
  logic [15:0] wb_rdata;
  logic        wb_ack;
  logic        wb_stall;

  int n_chk;
  int n_fail;

  wb_master #(
    .OPTN_WB_DATA_WIDTH(16),
    .OPTN_WB_ADDR_WIDTH(32),
    .OPTN_DATA_WIDTH(32),
    .OPTN_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .i_biu_en(biu_en),
    .i_biu_we(biu_we),
    .i_biu_addr(biu_addr),
    .i_biu_data(biu_wdata),
    .o_biu_data(biu_rdata),
    .o_biu_busy(biu_busy),
    .o_biu_done(biu_done),
    .o_biu_err(biu_err),
    .o_wb_cyc(wb_cyc),
    .o_wb_stb(wb_stb),
    .o_wb_we(wb_we),
    .o_wb_sel(wb_sel),
    .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata),
    .i_wb_data(wb_rdata),
    .i_wb_ack(wb_ack),
    .i_wb_stall(wb_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] rd0;
    logic [15:0] rd1;
    int          stall0;
    int          lat;
    logic        noise;
    logic        chk_rd;
    logic        err;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] rdata;
    int          done_k;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input int id, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got 0x%0h, want 0x%0h",
               id, nm, act, exp);
    end
  endtask

  // Issue one request, act as slave, check beats and completion.
  // Entered and left 1 time unit after a rising edge.
  task automatic run(input int id, input vec_t v);
    int          nb;
    int          na;
    int          hold;
    int          stalls;
    int          done_k;
    bit          cyc_ok;
    int          ackq[$];
    logic [31:0] ba[2];
    logic [15:0] bd[2];
    logic        bwe[2];
    logic [1:0]  bsel[2];
    logic        err_at_done;
    logic        busy_at_done;
    logic [31:0] rd_at_done;

    nb = 0; na = 0; hold = 0; stalls = 0;
    done_k = -1; cyc_ok = 1'b1;
    err_at_done = 1'b0; busy_at_done = 1'b0;
    rd_at_done = '0;
    for (int i = 0; i < 2; i++) begin
      ba[i] = '0; bd[i] = '0; bwe[i] = 1'b0; bsel[i] = '0;
    end

    biu_en    = 1'b1;
    biu_we    = v.we;
    biu_addr  = v.addr;
    biu_wdata = v.wdata;
    @(posedge clk); #1;
    if (v.noise) begin
      biu_addr  = 32'h0000_9990;
      biu_wdata = 32'h1111_2222;
      biu_we    = ~v.we;
    end else begin
      biu_en = 1'b0;
    end
    chk(id, "busy_after_accept", biu_busy, 1);

    for (int k = 0; k < 40; k++) begin
      if (biu_done) begin
        done_k       = k;
        err_at_done  = biu_err;
        busy_at_done = biu_busy;
        rd_at_done   = biu_rdata;
        break;
      end
      if (!wb_cyc) cyc_ok = 1'b0;
      wb_stall = wb_stb && (nb == 0) && (stalls < v.stall0);
      if (wb_stb && nb == 0 && wb_addr == v.a0) hold++;
      if (wb_stall) stalls++;
      if (wb_stb && !wb_stall) begin
        if (nb < 2) begin
          ba[nb]   = wb_addr;
          bd[nb]   = wb_wdata;
          bwe[nb]  = wb_we;
          bsel[nb] = wb_sel;
        end
        nb++;
        ackq.push_back(k + v.lat);
      end
      wb_ack   = 1'b0;
      wb_rdata = 16'h0;
      if (ackq.size() > 0 && ackq[0] == k) begin
        void'(ackq.pop_front());
        wb_ack   = 1'b1;
        wb_rdata = (na == 0) ? v.rd0 : v.rd1;
        na++;
      end
      @(posedge clk); #1;
    end
    wb_ack   = 1'b0;
    wb_stall = 1'b0;
    wb_rdata = 16'h0;
    biu_en   = 1'b0;

    chk(id, "done_cycle", done_k, v.done_k);
    chk(id, "beats_issued", nb, 2);
    chk(id, "addr0", ba[0], v.a0);
    chk(id, "addr1", ba[1], v.a1);
    chk(id, "wdata0", bd[0], v.d0);
    chk(id, "wdata1", bd[1], v.d1);
    chk(id, "we0", bwe[0], v.we);
    chk(id, "we1", bwe[1], v.we);
    chk(id, "sel0", bsel[0], 2'b11);
    chk(id, "sel1", bsel[1], 2'b11);
    chk(id, "stb_hold_beat0", hold, v.stall0 + 1);
    chk(id, "cyc_held", cyc_ok, 1);
    chk(id, "err_at_done", err_at_done, v.err);
    chk(id, "busy_at_done", busy_at_done, 1);
    if (v.chk_rd)
      chk(id, "read_data", rd_at_done, v.rdata);

    @(posedge clk); #1;
    chk(id, "done_pulse_end", biu_done, 0);
    chk(id, "busy_end", biu_busy, 0);
    chk(id, "cyc_end", wb_cyc, 0);
    chk(id, "err_end", biu_err, 0);
  endtask

  initial begin
    vec_t tv;
    n_chk = 0;
    n_fail = 0;

    // we addr wdata rd0 rd1 stall lat noise chk_rd err a0 a1 d0 d1 rdata done_k
    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 16'h0, 16'h0,
                0, 0, 1'b0, 1'b0, 1'b0,
                32'h0000_0100, 32'h0000_0102, 16'hBEEF, 16'hDEAD,
                32'h0, 2};
    vecs[1] = '{1'b0, 32'h0000_0203, 32'h0, 16'h1234, 16'hABCD,
                0, 0, 1'b0, 1'b1, 1'b0,
                32'h0000_0200, 32'h0000_0202, 16'h0, 16'h0,
                32'hABCD_1234, 2};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 16'h0, 16'h0,
                3, 0, 1'b1, 1'b0, 1'b0,
                32'h0000_0100, 32'h0000_0102, 16'hF00D, 16'hCAFE,
                32'h0, 5};
    vecs[3] = '{1'b0, 32'h0000_0300, 32'h0, 16'h5555, 16'hAAAA,
                0, 4, 1'b0, 1'b1, 1'b0,
                32'h0000_0300, 32'h0000_0302, 16'h0, 16'h0,
                32'hAAAA_5555, 6};
    vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0, 16'h0F0F, 16'hF0F0,
                0, 1, 1'b0, 1'b1, 1'b0,
                32'hFFFF_FFFC, 32'hFFFF_FFFE, 16'h0, 16'h0,
                32'hF0F0_0F0F, 3};
    vecs[5] = '{1'b1, 32'h0000_000F, 32'h0123_4567, 16'h0, 16'h0,
                2, 2, 1'b0, 1'b0, 1'b0,
                32'h0000_000C, 32'h0000_000E, 16'h4567, 16'h0123,
                32'h0, 6};

    n_rst     = 1'b1;
    biu_en    = 1'b0;
    biu_we    = 1'b0;
    biu_addr  = '0;
    biu_wdata = '0;
    wb_rdata  = '0;
    wb_ack    = 1'b0;
    wb_stall  = 1'b0;
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(-1, "rst_cyc", wb_cyc, 0);
    chk(-1, "rst_stb", wb_stb, 0);
    chk(-1, "rst_we", wb_we, 0);
    chk(-1, "rst_sel", wb_sel, 0);
    chk(-1, "rst_addr", wb_addr, 0);
    chk(-1, "rst_wdata", wb_wdata, 0);
    chk(-1, "rst_busy", biu_busy, 0);
    chk(-1, "rst_done", biu_done, 0);
    chk(-1, "rst_err", biu_err, 0);
    chk(-1, "rst_rdata", biu_rdata, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run(i, vecs[i]);

    // Stray acks while idle must not pollute the next read.
    wb_ack   = 1'b1;
    wb_rdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(6, "idle_ack_busy", biu_busy, 0);
    chk(6, "idle_ack_done", biu_done, 0);
    wb_ack   = 1'b0;
    wb_rdata = 16'h0;
    run(6, vecs[1]);

    // Reset asserted mid-burst drops the bus at once.
    biu_en    = 1'b1;
    biu_we    = 1'b1;
    biu_addr  = 32'h0000_0100;
    biu_wdata = 32'h1357_2468;
    wb_stall  = 1'b1;
    @(posedge clk); #1;
    biu_en = 1'b0;
    chk(7, "pre_rst_cyc", wb_cyc, 1);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk(7, "midrst_cyc", wb_cyc, 0);
    chk(7, "midrst_stb", wb_stb, 0);
    chk(7, "midrst_busy", biu_busy, 0);
    chk(7, "midrst_done", biu_done, 0);
    @(posedge clk); #1;
    chk(7, "midrst_no_done", biu_done, 0);
    wb_stall = 1'b0;
    n_rst    = 1'b1;
    @(posedge clk); #1;
    chk(7, "post_rst_done", biu_done, 0);
    run(8, vecs[0]);

`ifdef WB_MASTER_TIMEOUT_EN
    // No acks at all: watchdog aborts 16 cycles after the last issue.
    tv        = vecs[1];
    tv.lat    = 1000;
    tv.chk_rd = 1'b0;
    tv.err    = 1'b1;
    tv.done_k = 18;
    run(9, tv);
`else
    tv = vecs[3];
    run(9, tv);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
